// File: rtl/rv32_pkg.sv
// Shared types and constants for the RV32I pipeline stages.
package rv32_pkg;

    localparam int WIDTH  = 32;
    localparam int LANE_W = 8;

    // Writeback source select; 2'b11 is reserved and decodes as ALU.
    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } res_src_e;

    // Byte access touches one lane; word access touches all four.
    function automatic logic [3:0] lane_mask(input logic byte_en, input logic [1:0] off);
        if (byte_en) lane_mask = 4'b0001 << off;
        else         lane_mask = 4'b1111;
    endfunction

endpackage

// File: rtl/mem_stage_m_w_data_ram.sv
// Synchronous single-port data RAM with per-lane write enables and a
// read-first registered read port that can hold its value during a stall.
module data_ram #(
    parameter int ADDR_W = 10,
    parameter int WIDTH  = 32
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [3:0]        wr_lane,
    input  logic [WIDTH-1:0]  wr_data,
    output logic [WIDTH-1:0]  rd_data
);
    localparam int LW = rv32_pkg::LANE_W;

    logic [WIDTH-1:0] mem [2**ADDR_W];

    // Lane-masked write; contents are never reset.
    always_ff @(posedge clk) begin
        for (int l = 0; l < 4; l++) begin
            if (wr_lane[l]) mem[addr][l*LW +: LW] <= wr_data[l*LW +: LW];
        end
    end

    // Read-first: a same-edge write is not seen by this read.
    always_ff @(posedge clk) begin
        if (clr)        rd_data <= '0;
        else if (rd_en) rd_data <= mem[addr];
    end

endmodule

// File: rtl/mem_stage_m_w.sv
// Memory stage and M/W pipeline register: stores/loads against the data
// RAM, registers the instruction into W and forms the writeback value.
module mem_stage_m_w
    import rv32_pkg::*;
#(
    parameter int WIDTH  = rv32_pkg::WIDTH,
    parameter int ADDR_W = 10
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             reg_wr_en_m_i,
    input  logic [1:0]       result_src_m_i,
    input  logic             mem_wr_en_m_i,
    input  logic             mem_byte_en_m_i,
    input  logic             mem_sign_ext_m_i,
    input  logic [WIDTH-1:0] alu_result_m_i,
    input  logic [WIDTH-1:0] rd_data2_m_i,
    input  logic [4:0]       wr_addr_m_i,
    input  logic [WIDTH-1:0] pc_plus_4_m_i,
    input  logic             stall_w_i,
    input  logic             flush_w_i,
    output logic             reg_wr_en_w_o,
    output logic [4:0]       wr_addr_w_o,
    output logic [WIDTH-1:0] result_w_o,
    output logic             misalign_w_o
);
    typedef struct packed {
        logic             reg_wr_en;
        logic [4:0]       wr_addr;
        logic [1:0]       result_src;
        logic [WIDTH-1:0] alu_result;
        logic [WIDTH-1:0] pc_plus_4;
        logic [1:0]       byte_off;
        logic             byte_en;
        logic             sign_ext;
        logic             misalign;
    } mw_t;

    mw_t              mw_d, mw_q;
    logic             store;
    logic             clr;
    logic [3:0]       wr_lane;
    logic [WIDTH-1:0] wr_data;
    logic [WIDTH-1:0] rd_data;
    logic [WIDTH-1:0] load_data;
    logic [LANE_W-1:0] load_byte;

    // Stores only commit on an edge that actually advances the pipe.
    assign store   = mem_wr_en_m_i & ~stall_w_i & ~flush_w_i & ~rst_i;
    assign wr_lane = store ? lane_mask(mem_byte_en_m_i, alu_result_m_i[1:0]) : 4'b0000;
    assign wr_data = mem_byte_en_m_i ? {(WIDTH/LANE_W){rd_data2_m_i[LANE_W-1:0]}}
                                     : rd_data2_m_i;
    assign clr     = rst_i | flush_w_i;

    data_ram #(
        .ADDR_W (ADDR_W),
        .WIDTH  (WIDTH)
    ) u_ram (
        .clk     (clk_i),
        .clr     (clr),
        .rd_en   (~stall_w_i),
        .addr    (alu_result_m_i[ADDR_W+1:2]),
        .wr_lane (wr_lane),
        .wr_data (wr_data),
        .rd_data (rd_data)
    );

    // Next M/W contents; misalign only flags real word memory accesses.
    always_comb begin
        mw_d            = '0;
        mw_d.reg_wr_en  = reg_wr_en_m_i;
        mw_d.wr_addr    = wr_addr_m_i;
        mw_d.result_src = result_src_m_i;
        mw_d.alu_result = alu_result_m_i;
        mw_d.pc_plus_4  = pc_plus_4_m_i;
        mw_d.byte_off   = alu_result_m_i[1:0];
        mw_d.byte_en    = mem_byte_en_m_i;
        mw_d.sign_ext   = mem_sign_ext_m_i;
        mw_d.misalign   = ~mem_byte_en_m_i & (alu_result_m_i[1:0] != 2'b00) &
                          (mem_wr_en_m_i | (result_src_m_i == RES_MEM));
    end

    // M/W register: reset/flush clear to a bubble, stall holds.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_w_i) mw_q <= '0;
        else if (!stall_w_i)    mw_q <= mw_d;
    end

    // Load alignment in W from the registered offset and flags.
    always_comb begin
        load_byte = rd_data[{mw_q.byte_off, 3'b000} +: LANE_W];
        load_data = rd_data;
        if (mw_q.byte_en) begin
            load_data = mw_q.sign_ext ? {{(WIDTH-LANE_W){load_byte[LANE_W-1]}}, load_byte}
                                      : {{(WIDTH-LANE_W){1'b0}}, load_byte};
        end
    end

    // Writeback mux; reserved encoding falls through to ALU.
    always_comb begin
        case (mw_q.result_src)
            RES_MEM: result_w_o = load_data;
            RES_PC4: result_w_o = mw_q.pc_plus_4;
            default: result_w_o = mw_q.alu_result;
        endcase
    end

    assign reg_wr_en_w_o = mw_q.reg_wr_en;
    assign wr_addr_w_o   = mw_q.wr_addr;
    assign misalign_w_o  = mw_q.misalign;

endmodule

// File: tb/tb_mem_stage_m_w.sv
// Self-checking bench for mem_stage_m_w: vector table plus hand-built
// stall/flush/reset sequences, checked through an expected-result queue.
module tb_mem_stage_m_w;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        reg_wr_en = 1'b0;
    logic [1:0]  result_src = 2'b00;
    logic        mem_wr_en = 1'b0;
    logic        mem_byte_en = 1'b0;
    logic        mem_sign_ext = 1'b0;
    logic [31:0] alu_result = '0;
    logic [31:0] rd_data2 = '0;
    logic [4:0]  wr_addr = '0;
    logic [31:0] pc_plus_4 = '0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        wen_w;
    logic [4:0]  waddr_w;
    logic [31:0] res_w;
    logic        mis_w;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_stage_m_w #(.WIDTH(32), .ADDR_W(10)) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .reg_wr_en_m_i    (reg_wr_en),
        .result_src_m_i   (result_src),
        .mem_wr_en_m_i    (mem_wr_en),
        .mem_byte_en_m_i  (mem_byte_en),
        .mem_sign_ext_m_i (mem_sign_ext),
        .alu_result_m_i   (alu_result),
        .rd_data2_m_i     (rd_data2),
        .wr_addr_m_i      (wr_addr),
        .pc_plus_4_m_i    (pc_plus_4),
        .stall_w_i        (stall),
        .flush_w_i        (flush),
        .reg_wr_en_w_o    (wen_w),
        .wr_addr_w_o      (waddr_w),
        .result_w_o       (res_w),
        .misalign_w_o     (mis_w)
    );

    typedef struct {
        string       nm;
        logic        rst, wen;
        logic [1:0]  src;
        logic        mwr, ben, sx;
        logic [31:0] alu, rd2;
        logic [4:0]  wa;
        logic [31:0] pc;
        logic        st, fl;
        logic [31:0] er;
        logic        ew;
        logic [4:0]  ea;
        logic        em;
    } vec_t;

    vec_t tbl[$];
    vec_t sb_q[$];

    function automatic vec_t v(string nm, logic wen, logic [1:0] src, logic mwr, logic ben,
                               logic sx, logic [31:0] alu, logic [31:0] rd2, logic [4:0] wa,
                               logic [31:0] pc, logic [31:0] er, logic ew, logic [4:0] ea,
                               logic em);
        vec_t x;
        x.nm = nm; x.rst = 1'b0; x.wen = wen; x.src = src; x.mwr = mwr; x.ben = ben;
        x.sx = sx; x.alu = alu; x.rd2 = rd2; x.wa = wa; x.pc = pc; x.st = 1'b0;
        x.fl = 1'b0; x.er = er; x.ew = ew; x.ea = ea; x.em = em;
        return x;
    endfunction

    function automatic vec_t sw(string nm, logic [31:0] a, logic [31:0] d);
        logic [1:0] lo;
        lo = a[1:0];
        return v(nm, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, a, d, 5'd0, 32'h0, a, 1'b0, 5'd0, lo != 2'b00);
    endfunction

    function automatic vec_t sb(string nm, logic [31:0] a, logic [31:0] d);
        return v(nm, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, a, d, 5'd0, 32'h0, a, 1'b0, 5'd0, 1'b0);
    endfunction

    function automatic vec_t lw(string nm, logic [31:0] a, logic [4:0] rd, logic [31:0] e, logic em);
        return v(nm, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, a, 32'h0, rd, 32'h0, e, 1'b1, rd, em);
    endfunction

    function automatic vec_t lb(string nm, logic [31:0] a, logic [4:0] rd, logic sx, logic [31:0] e);
        return v(nm, 1'b1, 2'b01, 1'b0, 1'b1, sx, a, 32'h0, rd, 32'h0, e, 1'b1, rd, 1'b0);
    endfunction

    function automatic vec_t op(string nm, logic [1:0] src, logic [31:0] alu, logic [31:0] pc,
                                logic [4:0] rd, logic [31:0] e);
        return v(nm, 1'b1, src, 1'b0, 1'b0, 1'b0, alu, 32'h0, rd, pc, e, 1'b1, rd, 1'b0);
    endfunction

    // Instruction whose W result must be an empty bubble.
    function automatic vec_t kill(vec_t x, logic r, logic s, logic f);
        x.rst = r; x.st = s; x.fl = f;
        x.er = '0; x.ew = 1'b0; x.ea = '0; x.em = 1'b0;
        return x;
    endfunction

    // Stalled instruction: W must keep showing the previous one.
    function automatic vec_t hold(vec_t x, vec_t w);
        x.st = 1'b1; x.er = w.er; x.ew = w.ew; x.ea = w.ea; x.em = w.em;
        return x;
    endfunction

    task automatic step(input vec_t x);
        vec_t e;
        @(negedge clk);
        rst = x.rst; reg_wr_en = x.wen; result_src = x.src; mem_wr_en = x.mwr;
        mem_byte_en = x.ben; mem_sign_ext = x.sx; alu_result = x.alu; rd_data2 = x.rd2;
        wr_addr = x.wa; pc_plus_4 = x.pc; stall = x.st; flush = x.fl;
        sb_q.push_back(x);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        checks++;
        if (wen_w !== e.ew || waddr_w !== e.ea || res_w !== e.er || mis_w !== e.em) begin
            failures++;
            $display("FAIL %s: got wen=%0b wa=%0d res=%h mis=%0b, want wen=%0b wa=%0d res=%h mis=%0b",
                     e.nm, wen_w, waddr_w, res_w, mis_w, e.ew, e.ea, e.er, e.em);
        end
    endtask

    initial begin
        vec_t w;

        // Reset with arbitrary inputs, then prove a store under reset is dropped.
        step(kill(op("rst_a", 2'b10, 32'h1234, 32'h55, 5'd9, 32'h0), 1'b1, 1'b0, 1'b0));
        step(kill(sw("rst_b", 32'h200, 32'hFFFF0000), 1'b1, 1'b0, 1'b0));
        step(sw("pre_100", 32'h100, 32'hCAFEF00D));
        step(kill(sw("rst_sw", 32'h100, 32'h0BADBAD0), 1'b1, 1'b0, 1'b0));
        step(lw("rst_keep", 32'h100, 5'd3, 32'hCAFEF00D, 1'b0));

        tbl.push_back(sw("sw_40",     32'h40,   32'hDEADBEEF));
        tbl.push_back(lw("lw_40",     32'h40,   5'd5,  32'hDEADBEEF, 1'b0));
        tbl.push_back(sw("sw_44",     32'h44,   32'h55667788));
        tbl.push_back(lw("lw_44",     32'h44,   5'd6,  32'h55667788, 1'b0));
        tbl.push_back(sw("sw_80",     32'h80,   32'h11223344));
        tbl.push_back(sb("sb_82",     32'h82,   32'h123456AA));
        tbl.push_back(lw("lw_80",     32'h80,   5'd7,  32'h11AA3344, 1'b0));
        tbl.push_back(lb("lb_82",     32'h82,   5'd8,  1'b1, 32'hFFFFFFAA));
        tbl.push_back(lb("lbu_82",    32'h82,   5'd9,  1'b0, 32'h000000AA));
        tbl.push_back(lb("lb_81",     32'h81,   5'd10, 1'b1, 32'h00000033));
        tbl.push_back(lb("lb_83",     32'h83,   5'd11, 1'b1, 32'h00000011));
        tbl.push_back(lb("lbu_80",    32'h80,   5'd12, 1'b0, 32'h00000044));
        tbl.push_back(op("wb_pc4",    2'b10, 32'h999,  32'h104, 5'd1, 32'h104));
        tbl.push_back(op("wb_alu",    2'b00, 32'h7,    32'h50,  5'd2, 32'h7));
        tbl.push_back(op("wb_rsv",    2'b11, 32'h5A5A, 32'h200, 5'd3, 32'h5A5A));
        tbl.push_back(sw("sw_wrap",   32'h1040, 32'h0F0F0F0F));
        tbl.push_back(lw("lw_alias",  32'h40,   5'd4,  32'h0F0F0F0F, 1'b0));
        tbl.push_back(lw("lw_43",     32'h43,   5'd12, 32'h0F0F0F0F, 1'b1));
        tbl.push_back(op("alu_43",    2'b00, 32'h43,   32'h0,   5'd13, 32'h43));
        tbl.push_back(sw("sw_46_mis", 32'h46,   32'hA1B2C3D4));
        tbl.push_back(lw("lw_44b",    32'h44,   5'd14, 32'hA1B2C3D4, 1'b0));
        tbl.push_back(lb("lbu_43",    32'h43,   5'd15, 1'b0, 32'h0000000F));
        tbl.push_back(lb("lb_47",     32'h47,   5'd16, 1'b1, 32'hFFFFFFA1));
        tbl.push_back(sw("sw_60",     32'h60,   32'h01010101));
        tbl.push_back(sw("sw_64",     32'h64,   32'h12121212));
        foreach (tbl[i]) step(tbl[i]);

        // Stall: W holds a load while the M store waits; flush then kills it.
        w = lw("stl_w", 32'h40, 5'd17, 32'h0F0F0F0F, 1'b0);
        step(w);
        for (int i = 0; i < 3; i++) step(hold(sw("stl_hold", 32'h60, 32'h77777777), w));
        step(kill(sw("stl_flush", 32'h60, 32'h77777777), 1'b0, 1'b1, 1'b1));
        step(lw("stl_nostore", 32'h60, 5'd18, 32'h01010101, 1'b0));

        // Stalled store completes once released.
        w = op("stl2_w", 2'b00, 32'h321, 32'h0, 5'd4, 32'h321);
        step(w);
        for (int i = 0; i < 3; i++) step(hold(sw("stl2_hold", 32'h60, 32'h77777777), w));
        step(sw("stl2_rel", 32'h60, 32'h77777777));
        step(lw("stl2_chk", 32'h60, 5'd19, 32'h77777777, 1'b0));

        // Flush of a register-writing op and of a store.
        step(kill(op("fl_op", 2'b00, 32'h123, 32'h0, 5'd7, 32'h0), 1'b0, 1'b0, 1'b1));
        step(kill(sw("fl_sw", 32'h64, 32'h99999999), 1'b0, 1'b0, 1'b1));
        step(lw("fl_chk", 32'h64, 5'd20, 32'h12121212, 1'b0));

        // Reset during a stall discards the held instruction.
        w = op("rs_w", 2'b00, 32'h88, 32'h0, 5'd9, 32'h88);
        step(w);
        step(hold(op("rs_hold", 2'b10, 32'h1, 32'h2, 5'd3, 32'h0), w));
        step(kill(op("rs_stall", 2'b10, 32'h1, 32'h2, 5'd3, 32'h0), 1'b1, 1'b1, 1'b0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
